rtype_reservation_station: RTL and testbench
============================================

RTYPE_RESERVATION_STATION -- requirements
Module: rtype_reservation_station

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 4, giving the number of station entries (2..8).
REQ-002 SHALL have ports `clock`  in  1  (the single clock); `reset_n`  in  1  (reset, asynchronous, active-low).
REQ-003 SHALL have dispatch ports `dispatch_valid` in 1; `dispatch_ready` out 1; `dispatch_op` in 6 (R-type opcode); `dispatch_dest_tag` in 7.
REQ-004 SHALL have per-operand ports `dispatch_src1_rdy` in 1; `dispatch_src1_tag` in 7; `dispatch_src1_value` in 32 (used if rdy); and the same three for src2.
REQ-005 SHALL have CDB snoop ports `cdb_valid` in 1; `cdb_tag` in 7; `cdb_value` in 32.
REQ-006 SHALL have issue ports `issue_valid` out 1; `issue_ready` in 1; `issue_op` out 6; `issue_src1`, `issue_src2` out 32; `issue_dest_tag` out 7.
REQ-007 SHALL have `flush` in 1 (synchronous clear) and `occupancy` out 4 (busy entry count).

Function
REQ-008 Each entry SHALL hold busy, op, dest_tag, and per operand a rdy bit, a 7-bit tag and a 32-bit value.
REQ-009 Dispatch accepted on rising edge when dispatch_valid && dispatch_ready; payload written into lowest-index free entry.
REQ-010 dispatch_ready SHALL be 1 iff at least one entry is free per registered state; same-cycle issue does not raise it.
REQ-011 Wakeup: on cdb_valid, every busy entry operand with rdy=0 and tag==cdb_tag SHALL capture cdb_value and set rdy at that edge.
REQ-012 Dispatch bypass: an accepted operand with rdy=0 whose tag equals cdb_tag while cdb_valid SHALL be written rdy=1 with cdb_value.
REQ-013 An entry is issue-eligible when busy and both rdy bits are 1; among eligible entries the oldest (dispatch order, age matrix) SHALL be selected.
REQ-014 Selected entry drives issue_op/src1/src2/dest_tag; entry cleared on issue_valid && issue_ready edge.
REQ-015 issue_valid SHALL stay asserted with stable payload until accepted (no retraction, no payload change while stalled).
REQ-016 Latency: dispatch with both operands ready -> issue_valid next cycle; CDB wakeup at edge N -> issue_valid after edge N.
REQ-017 Simultaneous dispatch and issue in one cycle SHALL both complete; occupancy net unchanged.
REQ-018 Full: dispatch_valid while dispatch_ready=0 SHALL be ignored, state unchanged.
REQ-019 occupancy SHALL equal number of busy entries (plus held output register when REQ-024 active).
REQ-020 flush SHALL clear all busy bits and age state at the edge; dispatch/issue in a flush cycle are discarded.

Reset
REQ-021 reset_n low SHALL asynchronously clear all entries, age matrix and output register.
REQ-022 During and after reset: dispatch_ready=1, issue_valid=0, occupancy=0, issue payload outputs 0.
REQ-023 Reset mid-operation SHALL drop all pending entries; no issue occurs until new dispatch.

Configuration
REQ-024 With RS_ISSUE_REG_EN defined: issue outputs come from a one-deep output register; selected entry moves into it (and is freed) when register empty or drained same cycle; latencies in REQ-016 increase by one cycle.
REQ-025 Without RS_ISSUE_REG_EN: issue outputs combinational from selected entry as in REQ-014.

Verification
REQ-026 Reset, then dispatch op=011011, dest=5, both rdy, values 3,4 -> next cycle issue_valid=1, src1=3, src2=4, dest_tag=5.
REQ-027 Dispatch src1 tag=9 not rdy; later cdb_valid, tag=9, value=0xDEADBEEF -> issue_valid next cycle, src1=0xDEADBEEF.
REQ-028 Dispatch src2 tag=12 not rdy in same cycle as cdb tag=12 value=7 -> entry issues with src2=7, no hang.
REQ-029 Fill 4 entries, issue_ready=0 -> dispatch_ready=0, occupancy=4; extra dispatch ignored; then issue_ready=1 -> issues in dispatch order.
REQ-030 Two entries wake in same CDB cycle (both wait tag 3) -> older issues first; both get same value.
REQ-031 Assert flush with 3 busy entries, or pull reset_n low mid-stall -> issue_valid=0, occupancy=0, dispatch_ready=1.

Source files
------------

// File: rtl/rtype_reservation_station_if.sv
`default_nettype none
// ============================================================================
// Module   : rtype_reservation_station_if
// Purpose  : Dispatch, CDB snoop, issue, flush and occupancy signals of the
//            R-type reservation station, grouped into one bundle.
//            master = the surrounding pipeline, slave = the station.
// Revision : 1.0  initial release
// ============================================================================
interface rtype_reservation_station_if;
  logic        dispatch_valid;
  logic        dispatch_ready;
  logic [5:0]  dispatch_op;
  logic [6:0]  dispatch_dest_tag;
  logic        dispatch_src1_rdy;
  logic [6:0]  dispatch_src1_tag;
  logic [31:0] dispatch_src1_value;
  logic        dispatch_src2_rdy;
  logic [6:0]  dispatch_src2_tag;
  logic [31:0] dispatch_src2_value;
  logic        cdb_valid;
  logic [6:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        issue_valid;
  logic        issue_ready;
  logic [5:0]  issue_op;
  logic [31:0] issue_src1;
  logic [31:0] issue_src2;
  logic [6:0]  issue_dest_tag;
  logic        flush;
  logic [3:0]  occupancy;

  modport master (
    output dispatch_valid, dispatch_op, dispatch_dest_tag,
    output dispatch_src1_rdy, dispatch_src1_tag, dispatch_src1_value,
    output dispatch_src2_rdy, dispatch_src2_tag, dispatch_src2_value,
    output cdb_valid, cdb_tag, cdb_value, issue_ready, flush,
    input  dispatch_ready, issue_valid, issue_op, issue_src1, issue_src2,
    input  issue_dest_tag, occupancy
  );

  modport slave (
    input  dispatch_valid, dispatch_op, dispatch_dest_tag,
    input  dispatch_src1_rdy, dispatch_src1_tag, dispatch_src1_value,
    input  dispatch_src2_rdy, dispatch_src2_tag, dispatch_src2_value,
    input  cdb_valid, cdb_tag, cdb_value, issue_ready, flush,
    output dispatch_ready, issue_valid, issue_op, issue_src1, issue_src2,
    output issue_dest_tag, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/rtype_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : rtype_reservation_station
// Purpose  : R-type reservation station. Entries wait for operands by
//            snooping the CDB, the oldest ready entry (age matrix) issues.
//            Optional macro RS_ISSUE_REG_EN adds a one-deep issue output
//            register (one extra cycle of issue latency).
// Revision : 1.0  initial release
// ============================================================================
module rtype_reservation_station #(
  parameter int NUM_ENTRIES = 4
) (
  input  logic                          clock,
  input  logic                          reset_n,
  rtype_reservation_station_if.slave    bus
);
  localparam int c_idx_w = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] r_busy, r_s1_rdy, r_s2_rdy;
  logic [5:0]             r_op     [NUM_ENTRIES];
  logic [6:0]             r_dest   [NUM_ENTRIES];
  logic [6:0]             r_s1_tag [NUM_ENTRIES];
  logic [6:0]             r_s2_tag [NUM_ENTRIES];
  logic [31:0]            r_s1_val [NUM_ENTRIES];
  logic [31:0]            r_s2_val [NUM_ENTRIES];
  // r_age[i][j] = 1 means entry i was dispatched before entry j
  logic [NUM_ENTRIES-1:0] r_age    [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] w_elig, w_older;
  logic                   w_free_found, w_old_found, w_dispatch, w_take;
  logic [c_idx_w-1:0]     w_free_idx, w_old_idx, w_take_idx;
  logic                   w_bp1, w_bp2;
  logic [3:0]             w_busy_cnt;

  assign w_elig     = r_busy & r_s1_rdy & r_s2_rdy;
  assign w_dispatch = bus.dispatch_valid & w_free_found & ~bus.flush;
  assign w_bp1 = bus.cdb_valid & ~bus.dispatch_src1_rdy & (bus.dispatch_src1_tag == bus.cdb_tag);
  assign w_bp2 = bus.cdb_valid & ~bus.dispatch_src2_rdy & (bus.dispatch_src2_tag == bus.cdb_tag);
  assign bus.dispatch_ready = w_free_found;

  // Lowest-index free entry; descending scan lets the lowest index win.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = c_idx_w'(i);
      end
    end
  end

  // Oldest eligible entry: eligible and no other eligible entry is older.
  always_comb begin
    w_older     = '0;
    w_old_found = 1'b0;
    w_old_idx   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && w_elig[j] && r_age[j][i]) w_older[i] = 1'b1;
      end
      if (w_elig[i] && !w_older[i]) begin
        w_old_found = 1'b1;
        w_old_idx   = c_idx_w'(i);
      end
    end
  end

  // Busy entry count.
  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) w_busy_cnt = w_busy_cnt + 4'(r_busy[i]);
  end

  // Entry storage: wakeup, free on issue, allocate on dispatch, age update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= '0;
      r_s1_rdy <= '0;
      r_s2_rdy <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_op[i]     <= '0;
        r_dest[i]   <= '0;
        r_s1_tag[i] <= '0;
        r_s2_tag[i] <= '0;
        r_s1_val[i] <= '0;
        r_s2_val[i] <= '0;
        r_age[i]    <= '0;
      end
    end else if (bus.flush) begin
      r_busy <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (r_busy[i] && bus.cdb_valid && !r_s1_rdy[i] && r_s1_tag[i] == bus.cdb_tag) begin
          r_s1_rdy[i] <= 1'b1;
          r_s1_val[i] <= bus.cdb_value;
        end
        if (r_busy[i] && bus.cdb_valid && !r_s2_rdy[i] && r_s2_tag[i] == bus.cdb_tag) begin
          r_s2_rdy[i] <= 1'b1;
          r_s2_val[i] <= bus.cdb_value;
        end
      end
      if (w_take) r_busy[w_take_idx] <= 1'b0;
      if (w_dispatch) begin
        r_busy[w_free_idx]   <= 1'b1;
        r_op[w_free_idx]     <= bus.dispatch_op;
        r_dest[w_free_idx]   <= bus.dispatch_dest_tag;
        r_s1_rdy[w_free_idx] <= bus.dispatch_src1_rdy | w_bp1;
        r_s1_tag[w_free_idx] <= bus.dispatch_src1_tag;
        r_s1_val[w_free_idx] <= w_bp1 ? bus.cdb_value : bus.dispatch_src1_value;
        r_s2_rdy[w_free_idx] <= bus.dispatch_src2_rdy | w_bp2;
        r_s2_tag[w_free_idx] <= bus.dispatch_src2_tag;
        r_s2_val[w_free_idx] <= w_bp2 ? bus.cdb_value : bus.dispatch_src2_value;
        // New entry is younger than every other entry.
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          r_age[w_free_idx][j] <= 1'b0;
          r_age[j][w_free_idx] <= (c_idx_w'(j) != w_free_idx);
        end
      end
    end
  end

`ifdef RS_ISSUE_REG_EN
  logic        r_out_valid;
  logic [5:0]  r_out_op;
  logic [31:0] r_out_src1, r_out_src2;
  logic [6:0]  r_out_dest;

  // Oldest ready entry moves to the output register when it is empty or drains.
  assign w_take     = w_old_found & (~r_out_valid | bus.issue_ready) & ~bus.flush;
  assign w_take_idx = w_old_idx;

  // One-deep issue output register; payload is zeroed whenever it empties.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_src1  <= '0;
      r_out_src2  <= '0;
      r_out_dest  <= '0;
    end else if (bus.flush) begin
      r_out_valid <= 1'b0;
      r_out_op    <= '0;
      r_out_src1  <= '0;
      r_out_src2  <= '0;
      r_out_dest  <= '0;
    end else if (!r_out_valid || bus.issue_ready) begin
      r_out_valid <= w_old_found;
      r_out_op    <= w_old_found ? r_op[w_old_idx]     : '0;
      r_out_src1  <= w_old_found ? r_s1_val[w_old_idx] : '0;
      r_out_src2  <= w_old_found ? r_s2_val[w_old_idx] : '0;
      r_out_dest  <= w_old_found ? r_dest[w_old_idx]   : '0;
    end
  end

  assign bus.issue_valid    = r_out_valid;
  assign bus.issue_op       = r_out_op;
  assign bus.issue_src1     = r_out_src1;
  assign bus.issue_src2     = r_out_src2;
  assign bus.issue_dest_tag = r_out_dest;
  assign bus.occupancy      = w_busy_cnt + 4'(r_out_valid);
`else
  logic               r_hold;
  logic [c_idx_w-1:0] r_hold_idx;
  logic               w_sel_found;
  logic [c_idx_w-1:0] w_sel_idx;

  // A stalled entry stays selected so a later-woken older entry cannot
  // replace the payload while issue_valid is held.
  assign w_sel_found = r_hold | w_old_found;
  assign w_sel_idx   = r_hold ? r_hold_idx : w_old_idx;
  assign w_take      = w_sel_found & bus.issue_ready & ~bus.flush;
  assign w_take_idx  = w_sel_idx;

  // Remember the presented entry while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hold     <= 1'b0;
      r_hold_idx <= '0;
    end else if (bus.flush) begin
      r_hold <= 1'b0;
    end else begin
      r_hold     <= w_sel_found & ~bus.issue_ready;
      r_hold_idx <= w_sel_idx;
    end
  end

  // Issue outputs straight from the selected entry, zero when idle.
  always_comb begin
    bus.issue_valid    = w_sel_found;
    bus.issue_op       = '0;
    bus.issue_src1     = '0;
    bus.issue_src2     = '0;
    bus.issue_dest_tag = '0;
    if (w_sel_found) begin
      bus.issue_op       = r_op[w_sel_idx];
      bus.issue_src1     = r_s1_val[w_sel_idx];
      bus.issue_src2     = r_s2_val[w_sel_idx];
      bus.issue_dest_tag = r_dest[w_sel_idx];
    end
  end

  assign bus.occupancy = w_busy_cnt;
`endif
endmodule
`default_nettype wire

// File: tb/tb_rtype_reservation_station.sv
`default_nettype none
// ============================================================================
// Module   : tb_rtype_reservation_station
// Purpose  : Scoreboard bench for rtype_reservation_station. A queue-based
//            reference model predicts issues; a monitor checks them.
// Revision : 1.0  initial release
// ============================================================================
module tb_rtype_reservation_station;
  localparam int NUM = 4;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  rtype_reservation_station_if bus();
  rtype_reservation_station #(.NUM_ENTRIES(NUM)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          id;
    logic [5:0]  op;
    logic [6:0]  dest;
    logic        r1;
    logic [6:0]  t1;
    logic [31:0] v1;
    logic        r2;
    logic [6:0]  t2;
    logic [31:0] v2;
  } ent_t;

  ent_t        pend[$];      // waiting instructions, oldest first
  logic [76:0] exp_q[$];     // expected issue payloads {op,src1,src2,dest}
  int          pres_id = -1; // instruction presented while stalled
  int          next_id = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  logic        s_dv, s_r1, s_r2, s_cv, s_ir, s_flush;
  logic [5:0]  s_op;
  logic [6:0]  s_dest, s_t1, s_t2, s_ct;
  logic [31:0] s_v1, s_v2, s_cval;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  task automatic idle();
    s_dv = 0; s_r1 = 0; s_r2 = 0; s_cv = 0; s_ir = 0; s_flush = 0;
    s_op = 0; s_dest = 0; s_t1 = 0; s_t2 = 0; s_ct = 0;
    s_v1 = 0; s_v2 = 0; s_cval = 0;
  endtask

  task automatic apply();
    bus.dispatch_valid      = s_dv;
    bus.dispatch_op         = s_op;
    bus.dispatch_dest_tag   = s_dest;
    bus.dispatch_src1_rdy   = s_r1;
    bus.dispatch_src1_tag   = s_t1;
    bus.dispatch_src1_value = s_v1;
    bus.dispatch_src2_rdy   = s_r2;
    bus.dispatch_src2_tag   = s_t2;
    bus.dispatch_src2_value = s_v2;
    bus.cdb_valid           = s_cv;
    bus.cdb_tag             = s_ct;
    bus.cdb_value           = s_cval;
    bus.issue_ready         = s_ir;
    bus.flush               = s_flush;
  endtask

  // Which waiting instruction the station should be presenting now.
  task automatic model_present(output bit found, output int idx);
    found = 0;
    idx   = 0;
    for (int i = 0; i < pend.size(); i++) begin
      if (!found && ((pres_id >= 0) ? (pend[i].id == pres_id) : (pend[i].r1 && pend[i].r2))) begin
        found = 1;
        idx   = i;
      end
    end
  endtask

  // Effect of the coming clock edge on the model, given the driven inputs.
  task automatic model_update();
    bit   acc, pf;
    int   pi;
    ent_t e;
    if (s_flush) begin
      pend.delete();
      pres_id = -1;
      return;
    end
    acc = s_dv && (pend.size() < NUM);
    model_present(pf, pi);
    if (pf) begin
      if (s_ir) begin
        exp_q.push_back({pend[pi].op, pend[pi].v1, pend[pi].v2, pend[pi].dest});
        pend.delete(pi);
        pres_id = -1;
      end else begin
        pres_id = pend[pi].id;
      end
    end
    for (int i = 0; i < pend.size(); i++) begin
      e = pend[i];
      if (s_cv && !e.r1 && e.t1 == s_ct) begin e.r1 = 1; e.v1 = s_cval; end
      if (s_cv && !e.r2 && e.t2 == s_ct) begin e.r2 = 1; e.v2 = s_cval; end
      pend[i] = e;
    end
    if (acc) begin
      e.id = next_id++;
      e.op = s_op; e.dest = s_dest;
      e.t1 = s_t1; e.t2 = s_t2;
      e.r1 = s_r1 || (s_cv && s_t1 == s_ct);
      e.v1 = (!s_r1 && s_cv && s_t1 == s_ct) ? s_cval : s_v1;
      e.r2 = s_r2 || (s_cv && s_t2 == s_ct);
      e.v2 = (!s_r2 && s_cv && s_t2 == s_ct) ? s_cval : s_v2;
      pend.push_back(e);
    end
  endtask

  // One cycle: check registered-state outputs, drive inputs, advance model.
  task automatic step();
    bit pf;
    int pi;
    @(posedge clock);
    #1;
    model_present(pf, pi);
    chk("dispatch_ready", 128'(bus.dispatch_ready), 128'(pend.size() < NUM));
    chk("occupancy", 128'(bus.occupancy), 128'(pend.size()));
    chk("issue_valid", 128'(bus.issue_valid), 128'(pf));
    apply();
    if (reset_n) model_update();
  endtask

  task automatic disp(input logic [5:0] op, input logic [6:0] dest,
                      input logic r1, input logic [6:0] t1, input logic [31:0] v1,
                      input logic r2, input logic [6:0] t2, input logic [31:0] v2);
    s_dv = 1; s_op = op; s_dest = dest;
    s_r1 = r1; s_t1 = t1; s_v1 = v1;
    s_r2 = r2; s_t2 = t2; s_v2 = v2;
  endtask

  // Monitor: every accepted issue must match the next predicted payload.
  initial begin
    logic [76:0] e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && bus.issue_valid === 1'b1 && bus.issue_ready === 1'b1 && bus.flush === 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL issue_unexpected: actual=issue dest=%0d required=no issue", bus.issue_dest_tag);
        end else begin
          e = exp_q.pop_front();
          chk("issue_payload", 128'({bus.issue_op, bus.issue_src1, bus.issue_src2, bus.issue_dest_tag}), 128'(e));
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    idle();
    apply();
    #1;
    chk("reset_dispatch_ready", 128'(bus.dispatch_ready), 128'(1));
    chk("reset_issue_valid", 128'(bus.issue_valid), 128'(0));
    chk("reset_occupancy", 128'(bus.occupancy), 128'(0));
    chk("reset_payload", 128'({bus.issue_op, bus.issue_src1, bus.issue_src2, bus.issue_dest_tag}), 128'(0));
    #21 reset_n = 1'b1;

    // Both operands ready: issues the next cycle.
    idle(); disp(6'b011011, 7'd5, 1, 7'd0, 32'd3, 1, 7'd0, 32'd4); step();
    idle(); s_ir = 1; step(); step();

    // Wakeup of src1 from the CDB.
    idle(); disp(6'd1, 7'd6, 0, 7'd9, 32'd0, 1, 7'd0, 32'd11); s_ir = 1; step();
    idle(); s_ir = 1; step(); step();
    s_cv = 1; s_ct = 7'd9; s_cval = 32'hDEADBEEF; step();
    idle(); s_ir = 1; step(); step();

    // Dispatch bypass: CDB broadcast in the dispatch cycle.
    idle(); disp(6'd2, 7'd7, 1, 7'd0, 32'd1, 0, 7'd12, 32'd0);
    s_cv = 1; s_ct = 7'd12; s_cval = 32'd7; s_ir = 1; step();
    idle(); s_ir = 1; step(); step();

    // Fill while stalled, extra dispatch ignored, then drain in order.
    for (int k = 0; k < 5; k++) begin
      idle(); disp(6'(k), 7'(20 + k), 1, 7'd0, 32'(k), 1, 7'd0, 32'(100 + k)); step();
    end
    idle(); step();
    s_ir = 1; repeat (6) step();

    // Two entries woken by the same broadcast: older first.
    for (int k = 0; k < 2; k++) begin
      idle(); disp(6'd3, 7'(30 + k), 0, 7'd3, 32'd0, 1, 7'd0, 32'(k)); step();
    end
    idle(); s_cv = 1; s_ct = 7'd3; s_cval = 32'h1234; step();
    idle(); s_ir = 1; repeat (3) step();

    // Flush with three busy entries.
    for (int k = 0; k < 3; k++) begin
      idle(); disp(6'd4, 7'(40 + k), 0, 7'd50, 32'd0, 1, 7'd0, 32'd0); step();
    end
    idle(); s_flush = 1; step();
    idle(); step(); step();

    // Reset while an issue is stalled.
    for (int k = 0; k < 2; k++) begin
      idle(); disp(6'd5, 7'(60 + k), 1, 7'd0, 32'd9, 1, 7'd0, 32'd8); step();
    end
    idle(); step(); step();
    #2 reset_n = 1'b0;
    pend.delete();
    pres_id = -1;
    #1;
    chk("midreset_issue_valid", 128'(bus.issue_valid), 128'(0));
    chk("midreset_occupancy", 128'(bus.occupancy), 128'(0));
    chk("midreset_dispatch_ready", 128'(bus.dispatch_ready), 128'(1));
    #10 reset_n = 1'b1;
    idle(); s_ir = 1; step(); step();

    // Randomized traffic.
    repeat (3000) begin
      s_dv    = ($urandom_range(0, 9) < 6);
      s_op    = 6'($urandom);
      s_dest  = 7'($urandom);
      s_r1    = 1'($urandom_range(0, 1));
      s_t1    = 7'($urandom_range(0, 7));
      s_v1    = $urandom;
      s_r2    = 1'($urandom_range(0, 1));
      s_t2    = 7'($urandom_range(0, 7));
      s_v2    = $urandom;
      s_cv    = ($urandom_range(0, 9) < 4);
      s_ct    = 7'($urandom_range(0, 7));
      s_cval  = $urandom;
      s_ir    = ($urandom_range(0, 9) < 6);
      s_flush = ($urandom_range(0, 99) == 0);
      step();
    end

    idle(); s_flush = 1; step();
    idle(); step(); step();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
